// File: rtl/vacc_baseline_reader.sv
// Baseline readout sequencer: walks pairs (a<=b) of a finished accumulator buffer, streams tagged results.
// Latency: buf_done -> first out_valid is READ_LATENCY+2 cycles; 1 word/cycle sustained afterwards.
// Backpressure: out_ready low holds the FIFO head; reads stop when credits run out. VACC_RD_LAST_EN adds out_last.
module vacc_baseline_reader #(
  parameter int INPUT_WIDTH   = 4,
  parameter int ACC_LEN_BITS  = 8,
  parameter int VECTOR_LENGTH = 32,
  parameter int READ_LATENCY  = 2,
  parameter int FIFO_DEPTH    = 4,
  localparam int ACC_WIDTH    = INPUT_WIDTH + ACC_LEN_BITS,
  localparam int VLB          = $clog2(VECTOR_LENGTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 buf_done,
  input  logic                 buf_done_sel,
  output logic [VLB-1:0]       ant_sel_a,
  output logic [VLB-1:0]       ant_sel_b,
  output logic                 buf_sel,
  input  logic [ACC_WIDTH-1:0] din_a,
  input  logic [ACC_WIDTH-1:0] din_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_a,
  output logic [ACC_WIDTH-1:0] out_b,
  output logic [VLB-1:0]       out_ant_a,
  output logic [VLB-1:0]       out_ant_b,
  output logic                 busy,
  output logic                 overrun
`ifdef VACC_RD_LAST_EN
  ,
  output logic                 out_last
`endif
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
  localparam logic [VLB-1:0] VMAX = VLB'(VECTOR_LENGTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef struct packed {
`ifdef VACC_RD_LAST_EN
    logic                 last;
`endif
    logic [VLB-1:0]       ant_a;
    logic [VLB-1:0]       ant_b;
    logic [ACC_WIDTH-1:0] dat_a;
    logic [ACC_WIDTH-1:0] dat_b;
  } word_t;

  state_t               state;
  logic [VLB-1:0]       a, b;
  logic [VLB-1:0]       last_a, last_b;
  logic                 pend_vld, pend_sel;

  logic [READ_LATENCY-1:0] sr_vld;
  logic [VLB-1:0]          sr_a [READ_LATENCY];
  logic [VLB-1:0]          sr_b [READ_LATENCY];
`ifdef VACC_RD_LAST_EN
  logic [READ_LATENCY-1:0] sr_last;
`endif

  word_t                fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0]       wr_ptr, rd_ptr;
  logic [FAW:0]         fifo_count;
  logic                 fifo_push, fifo_pop;
  word_t                wr_word, rd_word;

  logic [CW-1:0]        in_flight;
  logic                 issue;
  logic                 final_issue;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + CW'(sr_vld[i]);
    end
  end

  // Credits cover both the read pipeline and the FIFO, so a capture never finds the FIFO full.
  assign issue       = (state == READ) && ((in_flight + CW'(fifo_count)) < CW'(FIFO_DEPTH));
  assign final_issue = issue && (a == VMAX) && (b == VMAX);

  // The address is presented in the issuing cycle so the tag line lines up with READ_LATENCY exactly.
  assign ant_sel_a = issue ? a : last_a;
  assign ant_sel_b = issue ? b : last_b;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      last_a   <= '0;
      last_b   <= '0;
      buf_sel  <= 1'b0;
      pend_vld <= 1'b0;
      pend_sel <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (buf_done && (state != IDLE)) begin
        pend_vld <= 1'b1;
        pend_sel <= buf_done_sel;
        if (pend_vld) overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (buf_done || pend_vld) begin
            state    <= READ;
            buf_sel  <= buf_done ? buf_done_sel : pend_sel;
            pend_vld <= 1'b0;
            a        <= '0;
            b        <= '0;
          end
        end
        READ: begin
          if (issue) begin
            last_a <= a;
            last_b <= b;
            if (b == VMAX) begin
              a <= a + VLB'(1);
              b <= a + VLB'(1);
            end else begin
              b <= b + VLB'(1);
            end
            if (final_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          // A request arriving on the drain-complete cycle starts at once; it overrides the pending update above.
          if (sr_vld == '0) begin
            if (buf_done || pend_vld) begin
              state    <= READ;
              buf_sel  <= buf_done ? buf_done_sel : pend_sel;
              pend_vld <= 1'b0;
              a        <= '0;
              b        <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_vld <= '0;
`ifdef VACC_RD_LAST_EN
      sr_last <= '0;
`endif
      for (int i = 0; i < READ_LATENCY; i++) begin
        sr_a[i] <= '0;
        sr_b[i] <= '0;
      end
    end else begin
      sr_vld[0] <= issue;
      sr_a[0]   <= a;
      sr_b[0]   <= b;
`ifdef VACC_RD_LAST_EN
      sr_last[0] <= final_issue;
`endif
      for (int i = 1; i < READ_LATENCY; i++) begin
        sr_vld[i] <= sr_vld[i-1];
        sr_a[i]   <= sr_a[i-1];
        sr_b[i]   <= sr_b[i-1];
`ifdef VACC_RD_LAST_EN
        sr_last[i] <= sr_last[i-1];
`endif
      end
    end
  end

  always_comb begin
    wr_word       = '0;
    wr_word.ant_a = sr_a[READ_LATENCY-1];
    wr_word.ant_b = sr_b[READ_LATENCY-1];
    wr_word.dat_a = din_a;
    wr_word.dat_b = din_b;
`ifdef VACC_RD_LAST_EN
    wr_word.last  = sr_last[READ_LATENCY-1];
`endif
  end

  assign fifo_push = sr_vld[READ_LATENCY-1];
  assign fifo_pop  = out_valid && out_ready;
  assign out_valid = (fifo_count != '0);
  assign rd_word   = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (fifo_push) begin
        fifo_mem[wr_ptr] <= wr_word;
        wr_ptr           <= wr_ptr + FAW'(1);
      end
      if (fifo_pop) rd_ptr <= rd_ptr + FAW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + (FAW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (FAW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign out_a     = rd_word.dat_a;
  assign out_b     = rd_word.dat_b;
  assign out_ant_a = rd_word.ant_a;
  assign out_ant_b = rd_word.ant_b;
`ifdef VACC_RD_LAST_EN
  assign out_last  = rd_word.last;
`endif

endmodule

// File: doc/vacc_baseline_reader.md
# vacc_baseline_reader

Readout sequencer downstream of the complex vector accumulator. When the accumulator announces a completed buffer, the block walks every baseline pair (a ≤ b) of the vector and drives the accumulator's two read ports (`ant_sel_a`, `ant_sel_b`, `buf_sel`). It absorbs the accumulator's fixed read latency and delivers the accumulated pairs, tagged with antenna indices, on a valid/ready stream with backpressure.

## Interface
- INPUT_WIDTH, 4, accumulator input sample width
- ACC_LEN_BITS, 8, log2 accumulation length; ACC_WIDTH = INPUT_WIDTH + ACC_LEN_BITS
- VECTOR_LENGTH, 32, antennas per vector (power of 2); VLB = log2(VECTOR_LENGTH)
- READ_LATENCY, 2, cycles from address to data at accumulator outputs
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥ READ_LATENCY+1)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- buf_done  in  1  one-cycle pulse: a buffer finished accumulating
- buf_done_sel  in  1  index of the finished buffer, sampled with buf_done
- ant_sel_a  out  VLB  read address, port A
- ant_sel_b  out  VLB  read address, port B
- buf_sel  out  1  buffer being read
- din_a  in  ACC_WIDTH  accumulator data, port A
- din_b  in  ACC_WIDTH  accumulator data, port B
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- out_a / out_b  out  ACC_WIDTH each  accumulated values
- out_ant_a / out_ant_b  out  VLB each  baseline indices
- busy  out  1  readout in progress (state ≠ IDLE)
- overrun  out  1  sticky: buf_done lost or collided

## Operation
- States: IDLE, READ, DRAIN.
- IDLE → READ:
  - Trigger: buf_done, or a pending request.
  - Action: latch buf_sel from buf_done_sel (or from the pending slot); set a = b = 0.
- READ, issue rule:
  - A read issues in any cycle where in_flight + fifo_count < FIFO_DEPTH.
  - An issue presents the current (a, b) and pushes a tag {a, b} into a READ_LATENCY-deep valid/tag shift line.
- READ, address advance after each issue:
  - If b == VECTOR_LENGTH-1: a ← a+1, b ← a+1.
  - Otherwise: b ← b+1.
  - Issuing (VECTOR_LENGTH-1, VECTOR_LENGTH-1) is the final issue; it moves the state to DRAIN.
- Baseline count: VECTOR_LENGTH·(VECTOR_LENGTH+1)/2 words per buffer; 528 at default.
- Capture: when a tag exits the shift line, write {din_a, din_b, tag} into the FIFO. The credit rule guarantees the FIFO is never full on a write.
- DRAIN → IDLE: when the shift line is empty. Waiting for the FIFO to empty is not required.
  - If a request is pending, go to READ directly instead. This costs no idle cycle.
- buf_done while not IDLE:
  - Store buf_done_sel in a one-deep pending slot.
  - If the slot is already full, overwrite it and set overrun.
- buf_done in the same cycle as the DRAIN→IDLE transition: treated as pending and started immediately.
- Output: FIFO head drives out_*. A pop occurs on out_valid & out_ready.
- ant_sel_a/ant_sel_b/buf_sel hold their last value when not issuing.
- Data widths pass through unchanged: no sign extension, no truncation.

## Timing
- Reset values (asynchronous on rst_n low):
  - State IDLE; all counters 0; FIFO empty; pending slot empty.
  - out_valid 0, out_a/out_b/out_ant_* 0, ant_sel_* 0, buf_sel 0, busy 0, overrun 0.
- Reset asserted mid-readout aborts the readout. In-flight and FIFO data are discarded.
- First address is driven the cycle after buf_done.
- The first word is written to the FIFO READ_LATENCY cycles after its address.
- out_valid rises one cycle after that FIFO write. Default buf_done → out_valid: 4 cycles.
- With out_ready held high, throughput is 1 word/cycle: no bubbles between the first and last word.
- Backpressure: out_valid and out_* hold stable while out_ready is low. Issuing stops once credits are exhausted.
- overrun clears only on reset.

## Configuration
- Macro: VACC_RD_LAST_EN.
- Defined:
  - Adds output port out_last (1 bit), carried in the FIFO.
  - out_last is asserted with the word for baseline (VECTOR_LENGTH-1, VECTOR_LENGTH-1); reset value 0.
- Undefined: port absent, FIFO width reduced accordingly. All other behaviour is identical.

## Test plan
- VECTOR_LENGTH=4, out_ready=1, buf_done with buf_done_sel=1:
  - Exactly 10 words, pairs (0,0),(0,1),(0,2),(0,3),(1,1)…(3,3).
  - buf_sel=1 throughout; first out_valid 4 cycles after buf_done; contiguous output.
  - The accumulator model returns data = {a, b} encodings; data must match tags.
- Same setup, out_ready toggling 1-in-3:
  - Same 10 words, in order, none duplicated or dropped.
  - out_* stable while stalled.
  - in_flight + fifo_count never exceeds 4.
- buf_done during READ:
  - A second full readout starts with the new buf_sel, with no idle cycle after DRAIN.
  - overrun stays 0.
- Three buf_done pulses during one readout (sel 0, 1, 0):
  - overrun = 1.
  - The next readout uses buf_sel = 0, the last pulse's value.
- rst_n low for 1 cycle mid-readout with 2 FIFO words present:
  - out_valid = 0 immediately; busy = 0.
  - The next buf_done produces a clean 10-word readout.
- With VACC_RD_LAST_EN defined:
  - out_last = 1 only on word (3,3).
  - A full 528-word default readout asserts out_last exactly once.
